// File: rtl/alu_accum_pkg.sv
// Shared FSM encoding and saturation limits for the ALU result accumulator.
package alu_accum_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DUMP = 2'd2} state_t;

  function automatic longint acc_max(input int nb);
    return (longint'(1) <<< (nb - 1)) - longint'(1);
  endfunction

  function automatic longint acc_min(input int nb);
    return -(longint'(1) <<< (nb - 1));
  endfunction
endpackage

// File: rtl/sat_add_s.sv
// Signed NB+NB adder that clamps to the representable range and flags overflow.
module sat_add_s
  import alu_accum_pkg::*;
#(
  parameter int NB = 18
) (
  input  logic signed [NB-1:0] a,
  input  logic signed [NB-1:0] b,
  output logic signed [NB-1:0] sum,
  output logic                 ovf
);
  localparam logic signed [NB-1:0] MAXV = NB'(acc_max(NB));
  localparam logic signed [NB-1:0] MINV = NB'(acc_min(NB));

  logic [NB:0] full;

  always_comb begin
    full = {a[NB-1], a} + {b[NB-1], b};
    // Differing top two bits of the widened sum means the true result left the NB-bit range.
    ovf  = full[NB] ^ full[NB-1];
    if (!ovf)          sum = full[NB-1:0];
    else if (full[NB]) sum = MINV;
    else               sum = MAXV;
  end
endmodule

// File: rtl/alu_result_accum.sv
// Windowed sum/mean/min/max/saturation accumulator for the ALU result stream.
module alu_result_accum
  import alu_accum_pkg::*;
#(
  parameter int NB_DATA  = 16,
  parameter int LOG2_WIN = 3,
  parameter int NB_ACC   = 18
) (
  input  logic                      clock,
  input  logic                      i_rst_n,
  input  logic signed [NB_DATA-1:0] i_data,
  input  logic                      i_valid,
  input  logic                      i_clear,
  output logic signed [NB_ACC-1:0]  o_sum,
  output logic signed [NB_ACC-1:0]  o_mean,
  output logic signed [NB_DATA-1:0] o_min,
  output logic signed [NB_DATA-1:0] o_max,
  output logic                      o_sat,
  output logic                      o_valid
);
  localparam int              CNT_W = LOG2_WIN + 1;
  localparam logic [CNT_W-1:0] WIN  = CNT_W'(1 << LOG2_WIN);

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic signed [NB_ACC-1:0]  acc, acc_nxt, add_sum, sample;
  logic signed [NB_DATA-1:0] mn, mx, mn_nxt, mx_nxt;
  logic                      sat, sat_nxt, add_ovf, start, done;

  assign sample = NB_ACC'(i_data);

  sat_add_s #(.NB(NB_ACC)) u_add (
    .a  (acc),
    .b  (sample),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  // Any sample outside ACCUM opens a new window, including one arriving during DUMP.
  always_comb begin
    start   = (state != ACCUM);
    acc_nxt = start ? sample : add_sum;
    mn_nxt  = (start || i_data < mn) ? i_data : mn;
    mx_nxt  = (start || i_data > mx) ? i_data : mx;
    sat_nxt = start ? 1'b0 : (sat | add_ovf);
    cnt_nxt = start ? CNT_W'(1) : cnt + 1'b1;
    done    = i_valid && !i_clear && (cnt_nxt == WIN);
  end

  always_comb begin
    state_nxt = state;
    o_valid   = (state == DUMP);
    if (i_clear)             state_nxt = IDLE;
    else if (i_valid)        state_nxt = (cnt_nxt == WIN) ? DUMP : ACCUM;
    else if (state == DUMP)  state_nxt = IDLE;
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mn     <= '0;
      mx     <= '0;
      sat    <= 1'b0;
      o_sum  <= '0;
      o_mean <= '0;
      o_min  <= '0;
      o_max  <= '0;
      o_sat  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (i_clear) begin
        cnt <= '0;
        acc <= '0;
        sat <= 1'b0;
      end else if (i_valid) begin
        cnt <= cnt_nxt;
        acc <= acc_nxt;
        mn  <= mn_nxt;
        mx  <= mx_nxt;
        sat <= sat_nxt;
      end
      if (done) begin
        o_sum  <= acc_nxt;
        o_mean <= acc_nxt >>> LOG2_WIN;
        o_min  <= mn_nxt;
        o_max  <= mx_nxt;
        o_sat  <= sat_nxt;
      end
    end
  end
endmodule

// File: doc/alu_result_accum.md
Name: alu_result_accum

Overview:
- Downstream stage of the two-operand ALU top.
- Consumes the ALU result word (o_dataC of the ALU top) with a valid strobe.
- Accumulates fixed-size windows of 2**LOG2_WIN samples and reports per window: saturated sum, arithmetic mean, minimum, maximum and a saturation flag.
- Result is published with a one-cycle valid pulse; used for on-chip checking of ALU sequences without a host.

Parameters:
- NB_DATA, 16, width of the signed input sample (matches the ALU data width).
- LOG2_WIN, 3, log2 of the window length; window WIN = 2**LOG2_WIN; legal range 0..8.
- NB_ACC, 18, signed accumulator/sum width; must be >= NB_DATA; saturation applies when the sum exceeds it.

Ports:
- clock  in  1  system clock, rising-edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_data  in  NB_DATA  signed two's-complement sample (ALU result).
- i_valid  in  1  i_data is valid this cycle; every valid sample is accepted (no backpressure).
- i_clear  in  1  synchronous abort of the current partial window.
- o_sum  out  NB_ACC  signed saturated window sum.
- o_mean  out  NB_ACC  o_sum arithmetic-shifted right by LOG2_WIN (floor toward -inf).
- o_min  out  NB_DATA  signed minimum sample of the window.
- o_max  out  NB_DATA  signed maximum sample of the window.
- o_sat  out  1  at least one saturation event occurred in the window.
- o_valid  out  1  one-cycle pulse: result outputs updated.

Behaviour:
- One clock; reset is asynchronous and active-low (clock, i_rst_n).
- Reset: state IDLE, count 0, internal sum/min/max/sat flag 0. All outputs 0, including o_valid.
- FSM states:
  - IDLE: waiting for the first sample.
  - ACCUM: partial window in progress.
  - DUMP: one cycle, o_valid=1.
- IDLE or DUMP with i_valid:
  - sum = sign-extended i_data; min = max = i_data; sat flag 0; count = 1.
  - Next state ACCUM, or DUMP if WIN==1.
- ACCUM with i_valid:
  - sum = sat(sum + sext(i_data)); min/max updated by signed compare; sat flag |= saturation this add; count++.
- Window completion: on acceptance of sample number WIN, the result registers load the final sum/mean/min/max/sat values for that window. State goes to DUMP and o_valid=1 during the following cycle.
- Latency: o_valid rises exactly 1 cycle after the WIN-th sample is accepted.
- Back-to-back windows: a sample valid in the DUMP cycle starts the next window. No sample is ever dropped.
- DUMP with no i_valid goes to IDLE.
- Saturation clamps to +2**(NB_ACC-1)-1 or -2**(NB_ACC-1). Accumulation continues from the clamped value.
- o_mean is computed from the clamped sum.
- Result outputs hold their last values until the next window completes. o_valid is 0 outside DUMP.
- i_clear priority: i_clear > i_valid. With i_clear=1:
  - State goes to IDLE; the partial window, count and sat flag are discarded; the sample presented that cycle is ignored.
  - Result outputs are unchanged.
  - If asserted in DUMP, o_valid still completes its current pulse; no further pulse follows.
- Reset asserted mid-window: everything returns to reset values immediately (asynchronous). A window starts fresh after deassertion.
- Count width is LOG2_WIN+1 bits; count never wraps, because it reloads on window start.

Decomposition:
- Package alu_accum_pkg holds:
  - FSM state encoding (IDLE=2'd0, ACCUM=2'd1, DUMP=2'd2).
  - Saturation limit constants as functions of NB_ACC.
- One sub-module: sat_add_s. Signed NB_ACC + NB_ACC adder that outputs the clamped result and an overflow flag. It is reusable by other accumulating stages.
- Everything else is inline: FSM, counter, min/max compare, result registers.

Test Plan:
- Defaults, 8 consecutive samples of -30 (ALU -15 + -15) → one o_valid pulse 1 cycle after the 8th sample; o_sum=-240, o_mean=-30, o_min=o_max=-30, o_sat=0.
- Samples 1..8 with idle gaps of 0-3 cycles → o_sum=36, o_mean=4, o_min=1, o_max=8, o_sat=0; o_valid pulses exactly once.
- 8 x 32767 → o_sum=131071, o_mean=16383, o_sat=1. Then 8 x -32768 → o_sum=-131072, o_mean=-16384, o_sat=1. The second window's sat flag is set independently, not carried over.
- 16 samples with i_valid held high continuously (8 x 5, then 8 x -2) → two o_valid pulses 8 cycles apart. Results: sum 40/mean 5, then sum -16/mean -2. The sample in the DUMP cycle is counted.
- 5 samples of 100, then i_clear together with a valid 7, then 8 x 0 → single o_valid with o_sum=0, o_min=o_max=0; the previous results hold until that pulse.
- i_rst_n pulled low asynchronously mid-clock after 3 samples → all outputs 0 immediately. After release, 8 x 1 → o_sum=8, o_mean=1.
